// File: rtl/writeback_regfile_if.sv
// Write-back / register-file bundle between the memory stage and decode.
// The master drives the completing instruction and the debug address; the slave answers.
interface writeback_regfile_if #(
  parameter int DATA_W = 64
);
  logic              instr_valid;
  logic [3:0]        icode;
  logic [3:0]        rA;
  logic [3:0]        rB;
  logic              cnd;
  logic [DATA_W-1:0] valE;
  logic [DATA_W-1:0] valM;
  logic [2:0]        stat_in;
  logic [DATA_W-1:0] valA;
  logic [DATA_W-1:0] valB;
  logic [2:0]        stat;
  logic              halted;
  logic [DATA_W-1:0] retired;
  logic [3:0]        dbg_addr;
  logic [DATA_W-1:0] dbg_data;

  modport master (
    output instr_valid, icode, rA, rB, cnd,
    output valE, valM, stat_in, dbg_addr,
    input  valA, valB, stat, halted,
    input  retired, dbg_data
  );

  modport slave (
    input  instr_valid, icode, rA, rB, cnd,
    input  valE, valM, stat_in, dbg_addr,
    output valA, valB, stat, halted,
    output retired, dbg_data
  );
endinterface

// File: rtl/writeback_regfile.sv
// Y86-64 write-back stage and 15-entry register file.
// Combinational decode reads, one-edge commit, status latch and retire counter.
module writeback_regfile #(
  parameter int         DATA_W = 64,
  parameter int         NREGS  = 15,
  parameter logic [3:0] RSP_ID = 4'h4,
  parameter logic [3:0] RNONE  = 4'hF
) (
  input  logic                clk,
  input  logic                rst_n,
  writeback_regfile_if.slave  bus
);

  localparam logic [2:0] S_AOK = 3'd1;

  logic [DATA_W-1:0] reg_q [NREGS];
  logic [2:0]        stat_q, stat_d;
  logic              halted_q, halted_d;
  logic [DATA_W-1:0] retired_q, retired_d;

  logic [3:0] src_a, src_b, dst_e, dst_m;
  logic       live, commit, halt;

  function automatic logic [DATA_W-1:0] rd(
    input logic [3:0] a
  );
    return (a == RNONE) ? '0 : reg_q[a];
  endfunction

  always_comb begin
    src_a = RNONE;
    unique case (1'b1)
      (bus.icode inside {4'h2, 4'h4, 4'h6, 4'hA}):
        src_a = bus.rA;
      (bus.icode inside {4'h9, 4'hB}):
        src_a = RSP_ID;
      default:
        src_a = RNONE;
    endcase
  end

  always_comb begin
    src_b = RNONE;
    unique case (1'b1)
      (bus.icode inside {4'h4, 4'h5, 4'h6}):
        src_b = bus.rB;
      (bus.icode inside {4'h8, 4'h9, 4'hA, 4'hB}):
        src_b = RSP_ID;
      default:
        src_b = RNONE;
    endcase
  end

  always_comb begin
    dst_e = RNONE;
    unique case (1'b1)
      (bus.icode == 4'h2):
        dst_e = bus.cnd ? bus.rB : RNONE;
      (bus.icode inside {4'h3, 4'h6}):
        dst_e = bus.rB;
      (bus.icode inside {4'h8, 4'h9, 4'hA, 4'hB}):
        dst_e = RSP_ID;
      default:
        dst_e = RNONE;
    endcase
  end

  always_comb begin
    dst_m = RNONE;
    if (bus.icode inside {4'h5, 4'hB})
      dst_m = bus.rA;
  end

  assign live   = bus.instr_valid && !halted_q;
  assign commit = live && (bus.stat_in == S_AOK);
  assign halt   = live && (bus.stat_in != S_AOK);

  always_comb begin
    stat_d    = stat_q;
    halted_d  = halted_q;
    retired_d = retired_q;
    if (commit)
      retired_d = retired_q + {{(DATA_W-1){1'b0}}, 1'b1};
    if (halt) begin
      stat_d   = bus.stat_in;
      halted_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_q    <= S_AOK;
      halted_q  <= 1'b0;
      retired_q <= '0;
    end else begin
      stat_q    <= stat_d;
      halted_q  <= halted_d;
      retired_q <= retired_d;
    end
  end

  // dstM is checked first so popq %rsp keeps the popped value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++)
        reg_q[i] <= '0;
    end else if (commit) begin
      for (int i = 0; i < NREGS; i++) begin
        if (dst_m == 4'(i))
          reg_q[i] <= bus.valM;
        else if (dst_e == 4'(i))
          reg_q[i] <= bus.valE;
      end
    end
  end

  assign bus.valA     = rd(src_a);
  assign bus.valB     = rd(src_b);
  assign bus.dbg_data = rd(bus.dbg_addr);
  assign bus.stat     = stat_q;
  assign bus.halted   = halted_q;
  assign bus.retired  = retired_q;

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile.
// Each task drives one scenario and checks results against hand-computed values.
module tb_writeback_regfile;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  writeback_regfile_if #(.DATA_W(64)) bus ();

  writeback_regfile dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic issue(
    input logic [3:0]  ic,
    input logic [3:0]  ra,
    input logic [3:0]  rb,
    input logic        c,
    input logic [63:0] ve,
    input logic [63:0] vm,
    input logic [2:0]  st
  );
    bus.instr_valid = 1'b1;
    bus.icode       = ic;
    bus.rA          = ra;
    bus.rB          = rb;
    bus.cnd         = c;
    bus.valE        = ve;
    bus.valM        = vm;
    bus.stat_in     = st;
  endtask

  task automatic idle();
    bus.instr_valid = 1'b0;
    bus.icode       = 4'h1;
    bus.rA          = 4'hF;
    bus.rB          = 4'hF;
    bus.cnd         = 1'b0;
    bus.valE        = '0;
    bus.valM        = '0;
    bus.stat_in     = 3'd1;
  endtask

  task automatic commit_edge();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic peek(input logic [3:0] a, output logic [63:0] d);
    bus.dbg_addr = a;
    #1;
    d = bus.dbg_data;
  endtask

  task automatic test_reset();
    logic [63:0] d;
    rst_n = 1'b0;
    idle();
    #12;
    total++;
    if (bus.stat !== 3'd1) begin
      bad++;
      $display("FAIL reset_stat got=%0d exp=1", bus.stat);
    end
    total++;
    if (bus.halted !== 1'b0) begin
      bad++;
      $display("FAIL reset_halted got=%0b exp=0", bus.halted);
    end
    total++;
    if (bus.retired !== 64'd0) begin
      bad++;
      $display("FAIL reset_retired got=%0h exp=0", bus.retired);
    end
    for (int i = 0; i < 16; i++) begin
      peek(4'(i), d);
      total++;
      if (d !== 64'd0) begin
        bad++;
        $display("FAIL reset_reg%0d got=%0h exp=0", i, d);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_irmovq();
    logic [63:0] d;
    @(negedge clk);
    issue(4'h3, 4'hF, 4'h2, 1'b0, 64'h1234, 64'h0, 3'd1);
    commit_edge();
    peek(4'h2, d);
    total++;
    if (d !== 64'h1234) begin
      bad++;
      $display("FAIL irmovq_reg2 got=%0h exp=1234", d);
    end
    total++;
    if (bus.retired !== 64'd1) begin
      bad++;
      $display("FAIL irmovq_retired got=%0d exp=1", bus.retired);
    end
  endtask

  task automatic test_cmov();
    logic [63:0] d;
    @(negedge clk);
    issue(4'h2, 4'h2, 4'h3, 1'b0, 64'h1234, 64'h0, 3'd1);
    #1;
    total++;
    if (bus.valA !== 64'h1234) begin
      bad++;
      $display("FAIL cmov_valA got=%0h exp=1234", bus.valA);
    end
    commit_edge();
    peek(4'h3, d);
    total++;
    if (d !== 64'h0) begin
      bad++;
      $display("FAIL cmov_nc_reg3 got=%0h exp=0", d);
    end
    total++;
    if (bus.retired !== 64'd2) begin
      bad++;
      $display("FAIL cmov_nc_retired got=%0d exp=2", bus.retired);
    end
    @(negedge clk);
    issue(4'h2, 4'h2, 4'h3, 1'b1, 64'h1234, 64'h0, 3'd1);
    commit_edge();
    peek(4'h3, d);
    total++;
    if (d !== 64'h1234) begin
      bad++;
      $display("FAIL cmov_c_reg3 got=%0h exp=1234", d);
    end
  endtask

  task automatic test_popq_rsp();
    logic [63:0] d;
    @(negedge clk);
    issue(4'hB, 4'h4, 4'hF, 1'b0, 64'h108, 64'hBEEF, 3'd1);
    commit_edge();
    peek(4'h4, d);
    total++;
    if (d !== 64'hBEEF) begin
      bad++;
      $display("FAIL popq_rsp_reg4 got=%0h exp=beef", d);
    end
    total++;
    if (bus.retired !== 64'd4) begin
      bad++;
      $display("FAIL popq_retired got=%0d exp=4", bus.retired);
    end
  endtask

  task automatic test_pushq();
    logic [63:0] d;
    @(negedge clk);
    issue(4'h3, 4'hF, 4'h1, 1'b0, 64'h77, 64'h0, 3'd1);
    commit_edge();
    @(negedge clk);
    issue(4'hA, 4'h1, 4'hF, 1'b0, 64'hF8, 64'h0, 3'd1);
    #1;
    total++;
    if (bus.valA !== 64'h77) begin
      bad++;
      $display("FAIL pushq_valA got=%0h exp=77", bus.valA);
    end
    total++;
    if (bus.valB !== 64'hBEEF) begin
      bad++;
      $display("FAIL pushq_valB got=%0h exp=beef", bus.valB);
    end
    commit_edge();
    peek(4'h4, d);
    total++;
    if (d !== 64'hF8) begin
      bad++;
      $display("FAIL pushq_reg4 got=%0h exp=f8", d);
    end
    peek(4'h1, d);
    total++;
    if (d !== 64'h77) begin
      bad++;
      $display("FAIL pushq_reg1 got=%0h exp=77", d);
    end
  endtask

  task automatic test_opq_rnone();
    logic [63:0] d;
    @(negedge clk);
    issue(4'h6, 4'h2, 4'h3, 1'b0, 64'h2468, 64'h0, 3'd1);
    #1;
    total++;
    if (bus.valB !== 64'h1234) begin
      bad++;
      $display("FAIL opq_valB got=%0h exp=1234", bus.valB);
    end
    commit_edge();
    peek(4'h3, d);
    total++;
    if (d !== 64'h2468) begin
      bad++;
      $display("FAIL opq_reg3 got=%0h exp=2468", d);
    end
    @(negedge clk);
    issue(4'h3, 4'hF, 4'hF, 1'b0, 64'hDEAD, 64'h0, 3'd1);
    commit_edge();
    peek(4'hF, d);
    total++;
    if (d !== 64'h0) begin
      bad++;
      $display("FAIL rnone_dbg got=%0h exp=0", d);
    end
    total++;
    if (bus.retired !== 64'd8) begin
      bad++;
      $display("FAIL rnone_retired got=%0d exp=8", bus.retired);
    end
  endtask

  task automatic test_idle();
    logic [63:0] d;
    @(negedge clk);
    issue(4'h3, 4'hF, 4'h5, 1'b0, 64'h99, 64'h0, 3'd1);
    bus.instr_valid = 1'b0;
    @(posedge clk);
    #1;
    idle();
    peek(4'h5, d);
    total++;
    if (d !== 64'h0) begin
      bad++;
      $display("FAIL idle_reg5 got=%0h exp=0", d);
    end
    total++;
    if (bus.retired !== 64'd8) begin
      bad++;
      $display("FAIL idle_retired got=%0d exp=8", bus.retired);
    end
  endtask

  task automatic test_halt();
    logic [63:0] d;
    @(negedge clk);
    issue(4'h5, 4'h5, 4'hF, 1'b0, 64'h0, 64'hAA, 3'd3);
    commit_edge();
    peek(4'h5, d);
    total++;
    if (d !== 64'h0) begin
      bad++;
      $display("FAIL halt_reg5 got=%0h exp=0", d);
    end
    total++;
    if (bus.stat !== 3'd3 || bus.halted !== 1'b1) begin
      bad++;
      $display("FAIL halt_stat got=%0d/%0b exp=3/1", bus.stat, bus.halted);
    end
    total++;
    if (bus.retired !== 64'd8) begin
      bad++;
      $display("FAIL halt_retired got=%0d exp=8", bus.retired);
    end
    @(negedge clk);
    issue(4'h3, 4'hF, 4'h5, 1'b0, 64'h55, 64'h0, 3'd1);
    commit_edge();
    @(negedge clk);
    issue(4'h3, 4'hF, 4'h5, 1'b0, 64'h66, 64'h0, 3'd4);
    commit_edge();
    peek(4'h5, d);
    total++;
    if (d !== 64'h0) begin
      bad++;
      $display("FAIL frozen_reg5 got=%0h exp=0", d);
    end
    total++;
    if (bus.stat !== 3'd3 || bus.retired !== 64'd8) begin
      bad++;
      $display("FAIL frozen_state got=%0d/%0d exp=3/8",
               bus.stat, bus.retired);
    end
  endtask

  task automatic test_async_reset();
    logic [63:0] d;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.halted !== 1'b0 || bus.stat !== 3'd1 || bus.retired !== 64'd0) begin
      bad++;
      $display("FAIL areset_halted got=%0b/%0d/%0d exp=0/1/0",
               bus.halted, bus.stat, bus.retired);
    end
    bus.dbg_addr = 4'h4;
    #0.1;
    total++;
    if (bus.dbg_data !== 64'h0) begin
      bad++;
      $display("FAIL areset_reg4 got=%0h exp=0", bus.dbg_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    issue(4'h3, 4'hF, 4'h2, 1'b0, 64'h4321, 64'h0, 3'd1);
    commit_edge();
    @(negedge clk);
    issue(4'h3, 4'hF, 4'h6, 1'b0, 64'h6666, 64'h0, 3'd1);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    idle();
    peek(4'h6, d);
    total++;
    if (d !== 64'h0) begin
      bad++;
      $display("FAIL areset_inflight_reg6 got=%0h exp=0", d);
    end
    peek(4'h2, d);
    total++;
    if (d !== 64'h0 || bus.retired !== 64'd0) begin
      bad++;
      $display("FAIL areset_midstream got=%0h/%0d exp=0/0",
               d, bus.retired);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [63:0] d;
    @(negedge clk);
    issue(4'h3, 4'hF, 4'h7, 1'b0, 64'h11, 64'h0, 3'd1);
    @(posedge clk);
    #1;
    issue(4'h6, 4'h7, 4'h7, 1'b0, 64'h22, 64'h0, 3'd1);
    #1;
    total++;
    if (bus.valA !== 64'h11) begin
      bad++;
      $display("FAIL b2b_valA got=%0h exp=11", bus.valA);
    end
    commit_edge();
    peek(4'h7, d);
    total++;
    if (d !== 64'h22 || bus.retired !== 64'd2) begin
      bad++;
      $display("FAIL b2b_reg7 got=%0h/%0d exp=22/2", d, bus.retired);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    bus.dbg_addr = 4'hF;
    test_reset();
    test_irmovq();
    test_cmov();
    test_popq_rsp();
    test_pushq();
    test_opq_rnone();
    test_idle();
    test_halt();
    test_async_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
